// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the clk_div_gen multi-channel clock divider.
// Contents:
//   fsm_state_t  - lock/reconfiguration FSM states
//   cfg_t        - per-channel configuration {div, high, phase}, held at a
//                  fixed internal width CFG_W (CNT_W <= CFG_W is assumed)
//   clamp_cfg    - legalises a requested configuration
//   start_value  - counter value a channel restarts from
package clk_div_gen_pkg;

   localparam int CFG_W = 32;

   typedef logic [CFG_W-1:0] cnt_ext_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2
   } fsm_state_t;

   typedef struct packed {
      cnt_ext_t div;
      cnt_ext_t high;
      cnt_ext_t phase;
   } cfg_t;

   // The order matters: phase and high are limited against the already
   // corrected period.
   function automatic cfg_t clamp_cfg(input cfg_t req);
      cfg_t r;
      r = req;
      if (r.div < cnt_ext_t'(2)) r.div = cnt_ext_t'(2);
      else                       r.div = r.div;
      if (r.phase >= r.div) r.phase = r.div - cnt_ext_t'(1);
      else                  r.phase = r.phase;
      if (r.high == cnt_ext_t'(0)) r.high = cnt_ext_t'(1);
      else                         r.high = r.high;
      if (r.high >= r.div) r.high = r.div - cnt_ext_t'(1);
      else                 r.high = r.high;
      return r;
   endfunction

   // (div - phase) mod div; a clamped phase is below div, so the only wrap
   // case is phase == 0.
   function automatic cnt_ext_t start_value(input cfg_t c);
      cnt_ext_t s;
      if (c.phase == cnt_ext_t'(0)) s = cnt_ext_t'(0);
      else                          s = c.div - c.phase;
      return s;
   endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Configuration port of clk_div_gen (valid/ready handshake).
// Signals:
//   cfg_valid  request            cfg_ready  accept (slave drives)
//   cfg_ch     target channel     cfg_sync   restart all channels on apply
//   cfg_div    period             cfg_high   high time
//   cfg_phase  rising-edge delay after restart
interface clk_div_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_high;
   logic [CNT_W-1:0] cfg_phase;
   logic             cfg_sync;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase, cfg_sync,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase, cfg_sync,
      output cfg_ready
   );

endinterface

// File: rtl/clk_div_gen_chan.sv
// One divider channel: period/high/phase registers, counter and registered
// outclk/tick.
// Ports:
//   refclk, rst  clock, asynchronous active-high reset
//   en           run enable; low freezes the channel at its start value
//   wr, wr_cfg   write a new (clamped) configuration and restart with it
//   restart      restart from the start value of the current configuration
//   outclk, tick divided clock and its rising-edge pulse
module clk_div_chan
   import clk_div_gen_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int DEF_DIV  = 2,
   parameter int DEF_HIGH = 1
) (
   input  logic refclk,
   input  logic rst,
   input  logic en,
   input  logic wr,
   input  cfg_t wr_cfg,
   input  logic restart,
   output logic outclk,
   output logic tick
);

   cfg_t             cfg_r;
   cfg_t             use_cfg;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next;
   logic             en_d_r;
   cnt_ext_t         start_s;
   logic             load_s;

   // A write takes effect at the same edge, so the restart uses the new values.
   assign use_cfg  = wr ? wr_cfg : cfg_r;
   assign start_s  = start_value(use_cfg);
   assign cnt_next = (cnt_ext_t'(cnt_r) == (cfg_r.div - cnt_ext_t'(1))) ?
                     {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
   // en_d_r low with en high is the first running edge after a freeze.
   assign load_s   = wr | restart | ~en_d_r;

   // Channel configuration, counter and registered outputs.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         cfg_r  <= '{div: cnt_ext_t'(DEF_DIV), high: cnt_ext_t'(DEF_HIGH),
                     phase: cnt_ext_t'(0)};
         cnt_r  <= CNT_W'(DEF_DIV - 1);
         en_d_r <= 1'b0;
         outclk <= 1'b0;
         tick   <= 1'b0;
      end else begin
         en_d_r <= en;
         if (wr) cfg_r <= wr_cfg;
         else    cfg_r <= cfg_r;
         if (!en) begin
            cnt_r  <= CNT_W'(start_s);
            outclk <= 1'b0;
            tick   <= 1'b0;
         end else if (load_s) begin
            cnt_r  <= CNT_W'(start_s);
            outclk <= (start_s < use_cfg.high);
            tick   <= (start_s == cnt_ext_t'(0));
         end else begin
            cnt_r  <= cnt_next;
            outclk <= (cnt_ext_t'(cnt_next) < cfg_r.high);
            tick   <= (cnt_next == {CNT_W{1'b0}});
         end
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel integer clock divider with run-time reconfiguration.
// Ports:
//   refclk  sole clock          rst     asynchronous active-high reset
//   en      per-channel enable  cfg     configuration port (slave side)
//   outclk  divided clocks      tick    pulse with each outclk rise
//   locked  all channels on a settled configuration
// An accepted request is clamped and held, written/applied one edge later,
// then locked/cfg_ready return after LOCK_CYCLES further edges.
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int LOCK_CYCLES = 8,
   parameter int DEF_DIV     = 2,
   parameter int DEF_HIGH    = 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   clk_div_gen_if.slave      cfg,
   output logic [NUM_CH-1:0] outclk,
   output logic [NUM_CH-1:0] tick,
   output logic              locked
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   fsm_state_t       state_r;
   logic [SET_W-1:0] settle_r;
   cfg_t             pend_r;
   logic [CH_W-1:0]  pend_ch_r;
   logic             pend_sync_r;
   cfg_t             req_s;
   cfg_t             clamp_s;
   logic             apply_s;

   assign req_s   = '{div:   cnt_ext_t'(cfg.cfg_div),
                      high:  cnt_ext_t'(cfg.cfg_high),
                      phase: cnt_ext_t'(cfg.cfg_phase)};
   assign clamp_s = clamp_cfg(req_s);
   assign apply_s = (state_r == ST_APPLY);

   // Lock FSM with request capture; locked/cfg_ready are registered here.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_SETTLE;
         settle_r      <= {SET_W{1'b0}};
         locked        <= 1'b0;
         cfg.cfg_ready <= 1'b0;
         pend_r        <= '{div: cnt_ext_t'(0), high: cnt_ext_t'(0),
                            phase: cnt_ext_t'(0)};
         pend_ch_r     <= {CH_W{1'b0}};
         pend_sync_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cfg.cfg_valid && cfg.cfg_ready) begin
                  pend_r        <= clamp_s;
                  pend_ch_r     <= cfg.cfg_ch;
                  pend_sync_r   <= cfg.cfg_sync;
                  cfg.cfg_ready <= 1'b0;
                  state_r       <= ST_APPLY;
               end else begin
                  state_r       <= ST_IDLE;
               end
            end
            ST_APPLY: begin
               locked   <= 1'b0;
               settle_r <= {SET_W{1'b0}};
               state_r  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_r == SET_W'(LOCK_CYCLES - 1)) begin
                  locked        <= 1'b1;
                  cfg.cfg_ready <= 1'b1;
                  settle_r      <= {SET_W{1'b0}};
                  state_r       <= ST_IDLE;
               end else begin
                  settle_r <= settle_r + SET_W'(1);
               end
            end
            default: begin
               locked        <= 1'b0;
               cfg.cfg_ready <= 1'b0;
               settle_r      <= {SET_W{1'b0}};
               state_r       <= ST_SETTLE;
            end
         endcase
      end
   end

   // A channel index with no matching channel writes nothing but still
   // goes through the full apply/settle sequence.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_chan #(
         .CNT_W    (CNT_W),
         .DEF_DIV  (DEF_DIV),
         .DEF_HIGH (DEF_HIGH)
      ) u_chan (
         .refclk  (refclk),
         .rst     (rst),
         .en      (en[i]),
         .wr      (apply_s && (pend_ch_r == CH_W'(i))),
         .wr_cfg  (pend_r),
         .restart (apply_s && pend_sync_r),
         .outclk  (outclk[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed and random reconfiguration,
// compared every edge against a model that places each channel at
// (start + edges since restart) mod div and derives locked/ready from the
// accept edge.
module tb_clk_div_gen;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 16;
   localparam int LOCK_CYCLES = 8;
   localparam int DEF_DIV     = 2;
   localparam int DEF_HIGH    = 1;
   localparam int CH_W        = 2;

   logic              refclk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] outclk;
   logic [NUM_CH-1:0] tick;
   logic              locked;

   clk_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

   clk_div_gen #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES),
      .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .en     (en),
      .cfg    (cfg_if),
      .outclk (outclk),
      .tick   (tick),
      .locked (locked)
   );

   always #5 refclk = ~refclk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int e;
   int m_div [NUM_CH];
   int m_high[NUM_CH];
   int m_phase[NUM_CH];
   int m_t0  [NUM_CH];
   bit m_need[NUM_CH];
   int low_from, high_from, apply_at;
   int p_ch, p_div, p_high, p_phase;
   bit p_sync;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
      end
   endtask

   task automatic model_reset();
      e = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_div[c] = DEF_DIV; m_high[c] = DEF_HIGH; m_phase[c] = 0;
         m_t0[c] = 0; m_need[c] = 1'b1;
      end
      low_from = 0; high_from = LOCK_CYCLES; apply_at = -1;
   endtask

   // one rising edge: advance the model, then compare all outputs
   task automatic step();
      logic [NUM_CH-1:0] exp_out, exp_tick;
      bit rs[NUM_CH];
      int pos, st, d, h, p;
      @(posedge refclk);
      e++;
      for (int c = 0; c < NUM_CH; c++) rs[c] = 1'b0;
      if (e == apply_at) begin
         if (p_ch < NUM_CH) begin
            m_div[p_ch] = p_div; m_high[p_ch] = p_high; m_phase[p_ch] = p_phase;
         end
         for (int c = 0; c < NUM_CH; c++) rs[c] = (c == p_ch) || p_sync;
         apply_at = -1;
      end
      if (cfg_if.cfg_valid === 1'b1 && (e - 1) >= high_from) begin
         d = int'(cfg_if.cfg_div); h = int'(cfg_if.cfg_high); p = int'(cfg_if.cfg_phase);
         if (d < 2) d = 2;
         if (p >= d) p = d - 1;
         if (h == 0) h = 1;
         if (h >= d) h = d - 1;
         p_div = d; p_high = h; p_phase = p;
         p_ch = int'(cfg_if.cfg_ch); p_sync = cfg_if.cfg_sync;
         apply_at = e + 1; low_from = e + 1; high_from = e + LOCK_CYCLES + 1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (!en[c]) begin
            m_need[c] = 1'b1;
            exp_out[c] = 1'b0; exp_tick[c] = 1'b0;
         end else begin
            if (rs[c] || m_need[c]) begin m_t0[c] = e; m_need[c] = 1'b0; end
            st  = (m_div[c] - m_phase[c]) % m_div[c];
            pos = (st + e - m_t0[c]) % m_div[c];
            exp_out[c]  = (pos < m_high[c]);
            exp_tick[c] = (pos == 0);
         end
      end
      #1;
      chk("outclk", 32'(outclk), 32'(exp_out));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("locked", 32'(locked), 32'((e >= high_from) || (e < low_from)));
      chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e >= high_from));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_outclk"}, 32'(outclk), 32'd0);
      chk({tag, "_tick"}, 32'(tick), 32'd0);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
   endtask

   task automatic scramble_cfg();
      cfg_if.cfg_ch    = CH_W'($urandom);
      cfg_if.cfg_div   = CNT_W'($urandom);
      cfg_if.cfg_high  = CNT_W'($urandom);
      cfg_if.cfg_phase = CNT_W'($urandom);
      cfg_if.cfg_sync  = 1'($urandom);
   endtask

   task automatic send_cfg(input int ch, input int dv, input int hi, input int ph, input bit sy);
      for (int w = 0; w < 40 && e < high_from; w++) step();
      if (e < high_from) chk("ready_timeout", 32'(cfg_if.cfg_ready), 32'd1);
      cfg_if.cfg_ch    = CH_W'(ch);
      cfg_if.cfg_div   = CNT_W'(dv);
      cfg_if.cfg_high  = CNT_W'(hi);
      cfg_if.cfg_phase = CNT_W'(ph);
      cfg_if.cfg_sync  = sy;
      cfg_if.cfg_valid = 1'b1;
      step();
      cfg_if.cfg_valid = 1'b0;
      scramble_cfg();
   endtask

   initial begin
      int idx;
      rst = 1'b1;
      en  = '1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_high = '0;
      cfg_if.cfg_phase = '0; cfg_if.cfg_sync = 1'b0;
      #12;
      chk_reset_vals("reset");
      rst = 1'b0;
      model_reset();

      // defaults: 1,0 toggling from the first edge, lock at edge 8
      for (int i = 0; i < 12; i++) step();

      // channel 1: div 5, high 2, phase 0
      send_cfg(1, 5, 2, 0, 1'b0);
      for (int i = 0; i < 14; i++) step();

      // phase relation through a synchronised restart
      send_cfg(0, 4, 2, 1, 1'b0);
      send_cfg(1, 4, 2, 0, 1'b1);
      for (int i = 0; i < 14; i++) step();

      // fully clamped request on channel 2
      send_cfg(2, 0, 0, 7, 1'b0);
      for (int i = 0; i < 12; i++) step();

      // channel 3 frozen for 10 cycles then restarted
      en[3] = 1'b0;
      for (int i = 0; i < 10; i++) step();
      en[3] = 1'b1;
      for (int i = 0; i < 8; i++) step();

      // randomized reconfiguration with enable toggling
      for (int k = 0; k < 10; k++) begin
         send_cfg(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                  1'($urandom_range(0, 1)));
         for (int j = 0; j < 16; j++) begin
            if ($urandom_range(0, 7) == 0) begin
               idx = int'($urandom_range(0, NUM_CH - 1));
               en[idx] = ~en[idx];
            end
            step();
         end
      end
      en = '1;
      for (int i = 0; i < 6; i++) step();

      // reset during settle: configuration lost, defaults back
      send_cfg(0, 7, 3, 2, 1'b1);
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      #1;
      chk_reset_vals("midreset");
      @(posedge refclk);
      #2;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 14; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised multi-channel clock generator: derives NUM_CH output clocks from `refclk` by integer division.
- Each channel has a programmable period, high time and phase offset, all reconfigurable at run time through a valid/ready port.
- `locked` is the lock indication. It drops during reconfiguration and re-asserts after a fixed settle time.
- Sits next to the PLL wrappers and produces low-rate, phase-related clocks/enables the PLL cannot synthesise.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of the divider, high-time and phase fields.
- LOCK_CYCLES, 8, settle cycles before `locked` asserts (>=1).
- DEF_DIV, 2, reset period of every channel (>=2).
- DEF_HIGH, 1, reset high time of every channel (1..DEF_DIV-1).

Ports:
- refclk  in  1  sole clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when valid&ready at a rising edge
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel
- cfg_div  in  CNT_W  period in refclk cycles
- cfg_high  in  CNT_W  cycles high per period
- cfg_phase  in  CNT_W  rising-edge delay, in cycles, after restart
- cfg_sync  in  1  1 = restart all channels together on apply
- outclk  out  NUM_CH  registered divided clocks
- tick  out  NUM_CH  1-cycle pulse coincident with each outclk rising edge
- locked  out  1  all channels running a stable configuration

Behaviour:
- One clock and one reset. `refclk` is the clock; `rst` is asynchronous and active-high.
- Reset values:
  - per channel: div=DEF_DIV, high=DEF_HIGH, phase=0, cnt=DEF_DIV-1
  - outputs: outclk=0, tick=0, locked=0, cfg_ready=0
  - FSM in SETTLE with settle counter 0
- Clamping on accept, in this order:
  - div<2 → 2
  - phase>=div → div-1
  - high=0 → 1
  - high>=div → div-1
- Start value of a channel: s = (div-phase) mod div.
- Per-channel counter, updated every edge while en=1:
  - cnt_next = (cnt==div-1) ? 0 : cnt+1
  - outclk <= (cnt_next < high)
  - tick <= (cnt_next == 0)
  - outclk and tick are registered together with cnt, so they are glitch-free.
- en=0: channel frozen at cnt=s, outclk=0, tick=0.
- en rising edge: at the next edge the channel loads cnt=s, outclk=(s<high), tick=(s==0).
- FSM states:
  - IDLE: cfg_ready=1. On valid&ready at edge E0 → APPLY. No other transitions.
  - APPLY (cfg_ready=0, locked=0), at edge E1:
    - clamped fields are written to the channel's active registers;
    - the channel restarts from s; if cfg_sync=1, every enabled channel restarts from its own s at the same edge;
    - settle counter cleared; → SETTLE.
  - SETTLE (cfg_ready=0, locked=0): counts edges. At edge E1+LOCK_CYCLES, locked<=1, cfg_ready<=1, → IDLE.
- `locked` falls at edge E0+1 (same edge as APPLY entry). It rises LOCK_CYCLES+1 edges after the accept.
- After reset release, `locked` rises at the LOCK_CYCLES-th edge; channels count from the first edge.
- cfg_ch >= NUM_CH:
  - still accepted and runs the full APPLY/SETTLE sequence;
  - no register written;
  - cfg_sync is still honoured.
- Channels not targeted and with cfg_sync=0 continue undisturbed through APPLY/SETTLE.
- en changes do not affect `locked`.
- Reset asserted mid-APPLY/SETTLE:
  - all state returns to reset values immediately;
  - any accepted configuration is lost.
- Configuration inputs need only be stable in the accept cycle; they are captured at E0.

Decomposition:
- Package clk_div_gen_pkg holds:
  - FSM state enum (IDLE, APPLY, SETTLE);
  - channel config struct {div, high, phase};
  - clamp function;
  - start-value function.
- One sub-module, clk_div_chan: a single counter/outclk/tick channel with load/restart inputs, instantiated NUM_CH times by generate.
- FSM and config capture stay in the top level.

Test Plan:
- Reset release with defaults and en=all 1s → every outclk toggles 1,0 each cycle starting the first edge; tick on each high; locked=1 at the 8th edge.
- Channel 1 set to div=5, high=2, phase=0, cfg_sync=0, accepted at E0 → cfg_ready/locked low at E0+1; outclk[1] pattern 1,1,0,0,0 from E0+1; tick[1] every 5 cycles; locked=1 at E0+9; other channels unchanged.
- Channel 0 div=4, high=2, phase=1; then channel 1 div=4, high=2, phase=0, cfg_sync=1 → after second apply, outclk[1] rises exactly 1 cycle before outclk[0], repeating every 4 cycles.
- Accept div=0, high=0, phase=7 on channel 2 → behaves as div=2, high=1, phase=1: outclk[2] 0,1,0,1 from apply.
- en[3] low for 10 cycles then high → outclk[3]=0 while low; restarts from s at the first edge after rising; locked stays 1 throughout.
- rst pulse during SETTLE → outputs immediately at reset values; new settle sequence completes; channel reverts to DEF_DIV/DEF_HIGH.
